cordic_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the iterative CORDIC cosine datapath, presented to the Nios II as a custom instruction with a start/done handshake. It latches the float angle and steps the datapath through three phases: pre-conversion (float to fixed theta), N_ITER micro-rotations, and post-conversion (fixed to float). It then returns the float result. The datapath arithmetic is external; this block owns only sequencing, handshaking and result capture.

---
 rtl/cordic_seq_ctrl_if.sv | 30 +++
 rtl/cordic_seq_ctrl.sv | 104 ++++++++++
 tb/tb_cordic_seq_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cordic_seq_ctrl_if.sv
// Custom-instruction handshake and datapath control bundle for the CORDIC sequencer.
// The slave modport is the sequencer; master is the Nios II side plus the datapath.
interface cordic_seq_ctrl_if;
   logic        clk_en;
   logic        start;
   logic [31:0] dataa;
   logic        done;
   logic [31:0] result;
   logic        busy;
   logic [31:0] dp_angle;
   logic        dp_pre_en;
   logic        dp_init;
   logic        dp_step;
   logic [4:0]  dp_iter;
   logic        dp_post_en;
   logic [31:0] dp_result;
   logic [7:0]  rej_cnt;

   modport slave (
      input  clk_en, start, dataa, dp_result,
      output done, result, busy, dp_angle, dp_pre_en, dp_init, dp_step,
             dp_iter, dp_post_en, rej_cnt
   );

   modport master (
      output clk_en, start, dataa, dp_result,
      input  done, result, busy, dp_angle, dp_pre_en, dp_init, dp_step,
             dp_iter, dp_post_en, rej_cnt
   );
endinterface

// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the iterative CORDIC cosine datapath: PRE -> N_ITER rotations -> POST,
// with a start/done custom-instruction handshake and registered control outputs.
module cordic_seq_ctrl #(
   parameter int N_ITER      = 22,
   parameter int PRE_CYCLES  = 2,
   parameter int POST_CYCLES = 3
) (
   input  logic              clk,
   input  logic              reset,
   cordic_seq_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, PRE, ITER, POST, DONE} state_t;

   localparam logic [4:0] PRE_LAST  = 5'(PRE_CYCLES - 1);
   localparam logic [4:0] ITER_LAST = 5'(N_ITER - 1);
   localparam logic [4:0] POST_LAST = 5'(POST_CYCLES - 1);

   state_t     state;
   logic [4:0] cnt;

   // NOTE: every register, including result and dp_angle, is async-reset so an aborted
   // operation leaves nothing stale; all state updates use non-blocking assignments.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         bus.done       <= 1'b0;
         bus.busy       <= 1'b0;
         bus.result     <= '0;
         bus.dp_angle   <= '0;
         bus.dp_pre_en  <= 1'b0;
         bus.dp_init    <= 1'b0;
         bus.dp_step    <= 1'b0;
         bus.dp_iter    <= '0;
         bus.dp_post_en <= 1'b0;
         bus.rej_cnt    <= '0;
      end else if (bus.clk_en) begin
         if (bus.start && state != IDLE && bus.rej_cnt != 8'hFF)
            bus.rej_cnt <= bus.rej_cnt + 8'd1;

         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  bus.dp_angle  <= bus.dataa;
                  cnt           <= '0;
                  state         <= PRE;
                  bus.busy      <= 1'b1;
                  bus.dp_pre_en <= 1'b1;
               end
            end

            PRE: begin
               if (cnt == PRE_LAST) begin
                  cnt           <= '0;
                  state         <= ITER;
                  bus.dp_pre_en <= 1'b0;
                  bus.dp_step   <= 1'b1;
                  bus.dp_init   <= 1'b1;
                  bus.dp_iter   <= '0;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end

            ITER: begin
               bus.dp_init <= 1'b0;
               if (cnt == ITER_LAST) begin
                  cnt            <= '0;
                  state          <= POST;
                  bus.dp_step    <= 1'b0;
                  bus.dp_iter    <= '0;
                  bus.dp_post_en <= 1'b1;
               end else begin
                  cnt         <= cnt + 5'd1;
                  bus.dp_iter <= cnt + 5'd1;
               end
            end

            POST: begin
               // dp_result is only guaranteed valid in the final POST cycle.
               if (cnt == POST_LAST) begin
                  cnt            <= '0;
                  state          <= DONE;
                  bus.result     <= bus.dp_result;
                  bus.dp_post_en <= 1'b0;
                  bus.done       <= 1'b1;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end

            DONE: begin
               state    <= IDLE;
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl: scoreboarded results, latency, iteration order,
// clock-enable stalls, rejected starts, mid-operation reset and reject-counter saturation.
module tb_cordic_seq_ctrl;

   localparam int N_ITER      = 22;
   localparam int PRE_CYCLES  = 2;
   localparam int POST_CYCLES = 3;
   localparam int LAT         = PRE_CYCLES + N_ITER + POST_CYCLES + 1;

   typedef struct packed {
      logic [31:0] angle;
      logic [31:0] res;
   } sb_t;

   logic clk;
   logic reset;
   cordic_seq_ctrl_if bus ();

   cordic_seq_ctrl #(
      .N_ITER      (N_ITER),
      .PRE_CYCLES  (PRE_CYCLES),
      .POST_CYCLES (POST_CYCLES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   sb_t sb_q[$];

   // Datapath stub: the float result is valid only in the last POST cycle.
   logic [31:0] stub_val;
   int          post_cnt;
   always @(posedge clk or posedge reset) begin
      if (reset)                         post_cnt <= 0;
      else if (bus.clk_en && bus.dp_post_en) post_cnt <= post_cnt + 1;
      else if (bus.clk_en)               post_cnt <= 0;
   end
   always_comb begin
      bus.dp_result = 32'hDEAD_BEEF;
      if (bus.dp_post_en && post_cnt == POST_CYCLES - 1) bus.dp_result = stub_val;
   end

   // Iteration monitor: dp_iter must count 0..N_ITER-1 on enabled cycles, init only at 0.
   int seq_err    = 0;
   int step_total = 0;
   int exp_iter   = 0;
   always @(negedge clk) begin
      if (reset || !bus.dp_step) begin
         exp_iter <= 0;
         if (!reset && bus.dp_iter !== 5'd0) seq_err <= seq_err + 1;
      end else if (bus.clk_en) begin
         if (bus.dp_iter !== 5'(exp_iter) || bus.dp_init !== (exp_iter == 0))
            seq_err <= seq_err + 1;
         step_total <= step_total + 1;
         exp_iter   <= exp_iter + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Starts one operation from IDLE and follows it to done; cycle 0 is the start edge.
   task automatic run_op(input string tag, input logic [31:0] angle, input logic [31:0] val,
                         input int gate_at, input int gate_len, input int rej_a,
                         input int rej_b, input int exp_lat);
      int  done_cyc = -1;
      int  busy_bad = 0;
      int  steps0   = step_total;
      int  err0     = seq_err;
      sb_t e;
      check({tag, "_idle_before"}, {31'd0, bus.busy}, 32'd0);
      bus.dataa = angle;
      bus.start = 1'b1;
      stub_val  = val;
      sb_q.push_back('{angle: angle, res: val});
      tick();
      bus.dataa = 32'h7FC0_0000;
      for (int cyc = 1; cyc <= exp_lat + 40 && done_cyc < 0; cyc++) begin
         bus.start  = (cyc == rej_a || cyc == rej_b);
         bus.clk_en = !(cyc >= gate_at && cyc < gate_at + gate_len);
         if (bus.busy !== 1'b1) busy_bad++;
         if (bus.done === 1'b1) begin
            done_cyc = cyc;
            check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check({tag, "_result"}, bus.result, e.res);
               check({tag, "_dp_angle"}, bus.dp_angle, e.angle);
            end
         end
         tick();
      end
      bus.start  = 1'b0;
      bus.clk_en = 1'b1;
      check({tag, "_latency"}, 32'(done_cyc), 32'(exp_lat));
      check({tag, "_busy_span"}, 32'(busy_bad), 32'd0);
      check({tag, "_step_count"}, 32'(step_total - steps0), 32'(N_ITER));
      check({tag, "_iter_seq"}, 32'(seq_err - err0), 32'd0);
      check({tag, "_idle_after"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gate;
      int done_cnt;
      reset      = 1'b1;
      bus.clk_en = 1'b1;
      bus.start  = 1'b0;
      bus.dataa  = '0;
      stub_val   = '0;
      repeat (3) tick();

      check("rst_done",    {31'd0, bus.done},       32'd0);
      check("rst_busy",    {31'd0, bus.busy},       32'd0);
      check("rst_pre_en",  {31'd0, bus.dp_pre_en},  32'd0);
      check("rst_init",    {31'd0, bus.dp_init},    32'd0);
      check("rst_step",    {31'd0, bus.dp_step},    32'd0);
      check("rst_post_en", {31'd0, bus.dp_post_en}, 32'd0);
      check("rst_result",  bus.result,              32'd0);
      check("rst_angle",   bus.dp_angle,            32'd0);
      check("rst_iter",    {27'd0, bus.dp_iter},    32'd0);
      check("rst_rej",     {24'd0, bus.rej_cnt},    32'd0);
      reset = 1'b0;
      tick();

      // Basic cos(1.0) operation.
      run_op("opA", 32'h3F80_0000, 32'h3F0A_5140, -10, 0, -1, -1, LAT);

      // Five stalled cycles somewhere inside ITER stretch latency by five.
      gate = $urandom_range(15, 4);
      run_op("stall", 32'h3F00_0000, 32'h3F60_A940, gate, 5, -1, -1, LAT + 5);

      // Starts while busy (including the DONE cycle) are rejected; next IDLE cycle accepts.
      run_op("rejA", 32'h3E80_0000, 32'h3F78_0A9A, -10, 0, 3, LAT, LAT);
      check("rej_after_two", {24'd0, bus.rej_cnt}, 32'd2);
      run_op("b2b", 32'h4000_0000, 32'hBED5_1132, -10, 0, -1, -1, LAT);
      check("rej_b2b_held", {24'd0, bus.rej_cnt}, 32'd2);

      // Asynchronous reset in the middle of ITER aborts without a done pulse.
      bus.dataa = 32'h4049_0FDB;
      bus.start = 1'b1;
      stub_val  = 32'hBF80_0000;
      tick();
      bus.start = 1'b0;
      repeat (9) tick();
      check("abort_in_iter", {31'd0, bus.dp_step}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("abort_busy",    {31'd0, bus.busy},    32'd0);
      check("abort_step",    {31'd0, bus.dp_step}, 32'd0);
      check("abort_iter",    {27'd0, bus.dp_iter}, 32'd0);
      check("abort_angle",   bus.dp_angle,         32'd0);
      check("abort_result",  bus.result,           32'd0);
      check("abort_rej",     {24'd0, bus.rej_cnt}, 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (i == 2) reset = 1'b0;
         if (bus.done === 1'b1) done_cnt++;
      end
      check("abort_no_done", 32'(done_cnt), 32'd0);
      run_op("fresh", 32'h3F80_0000, 32'h3F0A_5140, -10, 0, -1, -1, LAT);

      // Holding start: exactly one accept every LAT+1 edges, rejects saturate at 255.
      bus.dataa = 32'h3F80_0000;
      bus.start = 1'b1;
      repeat (200) tick();
      check("rej_200", {24'd0, bus.rej_cnt}, 32'(200 - (200 + LAT) / (LAT + 1)));
      repeat (100) tick();
      check("rej_sat", {24'd0, bus.rej_cnt}, 32'd255);
      bus.start = 1'b0;
      repeat (LAT + 2) tick();
      check("rej_sat_idle_busy", {31'd0, bus.busy}, 32'd0);
      check("rej_sat_hold", {24'd0, bus.rej_cnt}, 32'd255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
